// File: rtl/moore_seq_checker_pkg.sv
// Shared definitions for the Moore sequence generator/checker pair.
// State codes, checker FSM states and the code-to-out pairing rule.
package moore_seq_pkg;

  localparam logic [1:0] S0 = 2'b00;
  localparam logic [1:0] S1 = 2'b01;
  localparam logic [1:0] S2 = 2'b10;
  localparam logic [1:0] S3 = 2'b11;

  typedef enum logic [1:0] {
    HUNT   = 2'b00,
    SYNC   = 2'b01,
    LOCKED = 2'b10,
    MISS   = 2'b11
  } chk_state_e;

  function automatic logic pair_out(input logic [1:0] code);
    return ~code[0];
  endfunction

endpackage

// File: rtl/moore_seq_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins, then a
// same-cycle increment lands on 1.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= inc_i ? ONE : '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + ONE;
    end
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/moore_seq_checker.sv
// Receive-side checker for the 2-bit cyclic Moore state stream: acquires
// lock, flywheels the expected code, counts errors and reports cycles.
module moore_seq_checker
  import moore_seq_pkg::*;
#(
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned MAX_MISS = 2,
  parameter int unsigned ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [1:0]       state_in,
  input  logic             out_in,
  input  logic             err_clr,
  output logic             locked,
  output logic [1:0]       expected,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic             cycle_done
);

  localparam logic [3:0] LOCK_N = 4'(LOCK_CNT);
  localparam logic [2:0] MISS_N = 3'(MAX_MISS);

  chk_state_e state_q;
  logic [1:0] ref_q, ref_d;
  logic [3:0] good_q, good_inc;
  logic [2:0] miss_q, miss_inc;
  logic       locked_q, err_pulse_q, cycle_done_q;
  logic [1:0] expected_q;

  logic paired_w, startup_w, good_w, err_inc_w, tracking_w;

  assign paired_w   = (out_in == pair_out(state_in));
  assign startup_w  = (state_in == S0) && !out_in;
  assign good_w     = paired_w && (state_in == ref_q + 2'd1);
  assign tracking_w = (state_q == LOCKED) || (state_q == MISS);
  assign err_inc_w  = in_valid && tracking_w && !good_w;
  assign good_inc   = good_q + 4'd1;
  assign miss_inc   = miss_q + 3'd1;

  // While locked the reference flywheels regardless of what arrives.
  always_comb begin
    ref_d = ref_q;
    if (in_valid) begin
      case (state_q)
        HUNT:    if (paired_w || startup_w) ref_d = state_in;
        SYNC:    if (paired_w) ref_d = state_in;
        default: ref_d = ref_q + 2'd1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= HUNT;
      ref_q        <= S0;
      good_q       <= '0;
      miss_q       <= '0;
      locked_q     <= 1'b0;
      expected_q   <= S0;
      err_pulse_q  <= 1'b0;
      cycle_done_q <= 1'b0;
    end else begin
      err_pulse_q  <= 1'b0;
      cycle_done_q <= 1'b0;
      ref_q        <= ref_d;
      expected_q   <= ref_d + 2'd1;
      if (in_valid) begin
        case (state_q)
          HUNT: begin
            if (paired_w || startup_w) begin
              good_q  <= '0;
              state_q <= SYNC;
            end
          end
          SYNC: begin
            if (good_w) begin
              good_q <= good_inc;
              if (good_inc == LOCK_N) begin
                state_q  <= LOCKED;
                miss_q   <= '0;
                locked_q <= 1'b1;
              end
            end else if (paired_w) begin
              good_q <= '0;
            end else begin
              state_q <= HUNT;
            end
          end
          LOCKED, MISS: begin
            if (good_w) begin
              cycle_done_q <= (ref_q == S3);
              state_q      <= LOCKED;
              miss_q       <= '0;
            end else begin
              // miss_q is 0 whenever LOCKED, so miss_inc is 1 on a first miss.
              err_pulse_q <= 1'b1;
              miss_q      <= miss_inc;
              if (miss_inc >= MISS_N) begin
                state_q  <= HUNT;
                locked_q <= 1'b0;
              end else begin
                state_q <= MISS;
              end
            end
          end
          default: state_q <= HUNT;
        endcase
      end
    end
  end

  sat_counter #(.W(ERR_W)) u_err_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (err_clr),
    .inc_i  (err_inc_w),
    .count_o(err_count)
  );

  assign locked     = locked_q;
  assign expected   = expected_q;
  assign err_pulse  = err_pulse_q;
  assign cycle_done = cycle_done_q;

endmodule

// File: tb/tb_moore_seq_checker.sv
// Directed bench for moore_seq_checker with a behavioural reference model
// feeding an expected-value queue that is drained one cycle after each sample.
module tb_moore_seq_checker;

  localparam int LOCK_CNT = 4;
  localparam int MAX_MISS = 2;
  localparam int ERR_W    = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic [1:0]       state_in = 2'b00;
  logic             out_in = 1'b0;
  logic             err_clr = 1'b0;
  logic             locked;
  logic [1:0]       expected;
  logic             err_pulse;
  logic [ERR_W-1:0] err_count;
  logic             cycle_done;

  moore_seq_checker #(
    .LOCK_CNT(LOCK_CNT),
    .MAX_MISS(MAX_MISS),
    .ERR_W   (ERR_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .state_in  (state_in),
    .out_in    (out_in),
    .err_clr   (err_clr),
    .locked    (locked),
    .expected  (expected),
    .err_pulse (err_pulse),
    .err_count (err_count),
    .cycle_done(cycle_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       lk;
    logic [1:0] ex;
    logic       ep;
    logic       cd;
    logic [7:0] ec;
  } exp_t;

  exp_t sb[$];
  int   nchk = 0;
  int   nfail = 0;
  int   cd_seen = 0;

  // Model state: 0 HUNT, 1 SYNC, 2 LOCKED, 3 MISS
  int         m_st, m_good, m_miss, m_err;
  logic [1:0] m_ref;
  logic [1:0] nx;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_good = 0; m_miss = 0; m_err = 0; m_ref = 2'b00;
  endtask

  task automatic step(input logic v, input logic [1:0] s, input logic o, input logic c);
    exp_t       e;
    logic       paired, good;
    logic [1:0] nxt, old;
    in_valid = v; state_in = s; out_in = o; err_clr = c;
    e = '0;
    if (c) m_err = 0;
    if (v) begin
      nxt    = m_ref + 2'd1;
      paired = (o != s[0]);
      good   = paired && (s == nxt);
      case (m_st)
        0: if (paired || (s == 2'b00 && !o)) begin m_ref = s; m_good = 0; m_st = 1; end
        1: begin
          if (good) begin
            m_ref = s; m_good++;
            if (m_good == LOCK_CNT) begin m_st = 2; m_miss = 0; end
          end else if (paired) begin
            m_ref = s; m_good = 0;
          end else begin
            m_st = 0;
          end
        end
        default: begin
          old = m_ref; m_ref = nxt;
          if (good) begin
            e.cd = (old == 2'b11); m_st = 2; m_miss = 0;
          end else begin
            e.ep = 1'b1;
            if (m_err < 255) m_err++;
            m_miss = (m_st == 2) ? 1 : m_miss + 1;
            m_st = (m_miss >= MAX_MISS) ? 0 : 3;
          end
        end
      endcase
    end
    e.lk = (m_st >= 2);
    e.ex = m_ref + 2'd1;
    e.ec = 8'(m_err);
    sb.push_back(e);
    @(posedge clk); #1;
    e = sb.pop_front();
    if (cycle_done) cd_seen++;
    chk("locked", {7'd0, locked}, {7'd0, e.lk});
    chk("expected", {6'd0, expected}, {6'd0, e.ex});
    chk("err_pulse", {7'd0, err_pulse}, {7'd0, e.ep});
    chk("cycle_done", {7'd0, cycle_done}, {7'd0, e.cd});
    chk("err_count", err_count, e.ec);
  endtask

  task automatic clean(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b1, nx, ~nx[0], 1'b0);
      nx = nx + 2'd1;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_locked"}, {7'd0, locked}, 8'd0);
    chk({tag, "_expected"}, {6'd0, expected}, 8'd0);
    chk({tag, "_err_pulse"}, {7'd0, err_pulse}, 8'd0);
    chk({tag, "_cycle_done"}, {7'd0, cycle_done}, 8'd0);
    chk({tag, "_err_count"}, err_count, 8'd0);
  endtask

  initial begin
    int cd0;
    model_reset();
    nx = 2'b00;
    #12;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Acquisition from the S0/0 startup pattern
    step(1'b1, 2'b00, 1'b0, 1'b0);
    nx = 2'b01;
    clean(3);
    chk("lock_pending", {7'd0, locked}, 8'd0);
    clean(1);
    chk("lock_5th", {7'd0, locked}, 8'd1);
    cd0 = cd_seen;
    clean(8);
    chk("cycle_done_clean", 8'(cd_seen - cd0), 8'd2);
    chk("err_clean", err_count, 8'd0);

    // Single corrupted S2 while locked
    clean(1);
    step(1'b1, 2'b10, 1'b0, 1'b0);
    nx = 2'b11;
    chk("err_once", err_count, 8'd1);
    chk("exp_flywheel", {6'd0, expected}, 8'd3);
    chk("still_locked", {7'd0, locked}, 8'd1);
    clean(4);

    // Two consecutive misses drop lock, then relock
    step(1'b1, 2'b00, 1'b0, 1'b0);
    chk("miss1_locked", {7'd0, locked}, 8'd1);
    step(1'b1, 2'b00, 1'b0, 1'b0);
    chk("drop_lock", {7'd0, locked}, 8'd0);
    chk("err_two", err_count, 8'd3);
    clean(4);
    chk("relock_pending", {7'd0, locked}, 8'd0);
    clean(1);
    chk("relock", {7'd0, locked}, 8'd1);

    // in_valid gaps with junk on the bus
    cd0 = cd_seen;
    for (int i = 0; i < 8; i++) begin
      clean(1);
      step(1'b0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0);
    end
    chk("gap_err", err_count, 8'd3);
    chk("gap_cycle_done", 8'(cd_seen - cd0), 8'd2);
    chk("gap_locked", {7'd0, locked}, 8'd1);

    // Saturation and clear priority
    step(1'b0, 2'b00, 1'b0, 1'b1);
    chk("clr_alone", err_count, 8'd0);
    for (int i = 0; i < 256; i++) begin
      step(1'b1, nx, nx[0], 1'b0);
      nx = nx + 2'd1;
      clean(1);
    end
    chk("saturate", err_count, 8'd255);
    step(1'b1, nx, nx[0], 1'b1);
    nx = nx + 2'd1;
    chk("clr_with_err", err_count, 8'd1);
    clean(2);
    chk("pre_reset_locked", {7'd0, locked}, 8'd1);

    // Asynchronous reset between clock edges
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    clean(4);
    chk("post_rst_hunt", {7'd0, locked}, 8'd0);
    clean(1);
    chk("post_rst_relock", {7'd0, locked}, 8'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
